// File: rtl/ah_write_if.sv
// NIOS-side and write-master-side signals of the write path, bundled.
// master = the ah_write_top view, slave = the surrounding NIOS/write-master view.
interface ah_write_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 23
);
  logic [31:0]       write_addr;
  logic [31:0]       size;
  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              write_done;
  logic              write_err;
  logic              busy;
  logic [CNT_W-1:0]  words_left;
  logic              control_fixed_location;
  logic [ADDR_W-1:0] control_write_base;
  logic [ADDR_W-1:0] control_write_length;
  logic              control_go;
  logic              control_done;
  logic              user_write_buffer;
  logic [DATA_W-1:0] user_buffer_data;
  logic              user_buffer_full;

  modport master (
    input  write_addr, size, write_en, data_in, data_valid,
           control_done, user_buffer_full,
    output data_ready, write_done, write_err, busy, words_left,
           control_fixed_location, control_write_base, control_write_length,
           control_go, user_write_buffer, user_buffer_data
  );

  modport slave (
    output write_addr, size, write_en, data_in, data_valid,
           control_done, user_buffer_full,
    input  data_ready, write_done, write_err, busy, words_left,
           control_fixed_location, control_write_base, control_write_length,
           control_go, user_write_buffer, user_buffer_data
  );
endinterface

// File: rtl/ah_write_top.sv
// NIOS -> Avalon write-master bridge: validates a start request, programs the
// master, streams words through a one-entry output register, reports completion.
module ah_write_top #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 23
) (
  input  logic        clock,
  input  logic        reset,
  ah_write_if.master  bus,
  output logic [2:0]  dbg_state
);

  // Handshake: a word moves from NIOS when data_valid & data_ready in the same
  // cycle; a word moves to the master FIFO when user_write_buffer is high.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              ovalid;
  logic [DATA_W-1:0] odata;
  logic [CNT_W-1:0]  words_left_q;
  logic [ADDR_W-1:0] base_q, len_q;
  logic              busy_q, err_q;
  logic              start_ok, ready, push, accept;
  logic              unused_addr_hi;

  // Only aligned, non-zero lengths that fit the master's length port are legal.
  assign start_ok = (bus.size != 32'd0) && (bus.size[1:0] == 2'b00) &&
                    (bus.write_addr[1:0] == 2'b00) &&
                    (bus.size[31:ADDR_W] == '0);
  assign unused_addr_hi = ^bus.write_addr[31:ADDR_W];

  assign push   = ovalid && !bus.user_buffer_full;
  assign ready  = (state == STREAM) && (words_left_q != '0) &&
                  (!ovalid || !bus.user_buffer_full);
  assign accept = bus.data_valid && ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.write_en && start_ok) state_nxt = START;
      START:     state_nxt = STREAM;
      STREAM:    if ((words_left_q == '0) && !ovalid) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.control_done) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ovalid       <= 1'b0;
      odata        <= '0;
      words_left_q <= '0;
      base_q       <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= (state == IDLE) && bus.write_en && !start_ok;
      if ((state == IDLE) && bus.write_en && start_ok) begin
        base_q       <= bus.write_addr[ADDR_W-1:0];
        len_q        <= bus.size[ADDR_W-1:0];
        words_left_q <= bus.size[ADDR_W-1:2];
        busy_q       <= 1'b1;
      end else if (accept) begin
        words_left_q <= words_left_q - 1'b1;
      end
      if (state == DONE) busy_q <= 1'b0;
      // Accept wins over push so a simultaneous refill keeps the register full.
      if (accept) begin
        odata  <= bus.data_in;
        ovalid <= 1'b1;
      end else if (push) begin
        ovalid <= 1'b0;
      end
    end
  end

  assign bus.data_ready             = ready;
  assign bus.write_done             = (state == DONE);
  assign bus.write_err              = err_q;
  assign bus.busy                   = busy_q;
  assign bus.words_left             = words_left_q;
  assign bus.control_fixed_location = 1'b0;
  assign bus.control_write_base     = base_q;
  assign bus.control_write_length   = len_q;
  assign bus.control_go             = (state == START);
  assign bus.user_write_buffer      = push;
  assign bus.user_buffer_data       = odata;
  assign dbg_state                  = state;

endmodule

// File: tb/tb_ah_write_top.sv
// Directed bench for ah_write_top: start validation, streaming with backpressure,
// ignored restarts, mid-transfer reset and per-word countdown.
module tb_ah_write_top;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 23;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_STREAM = 3'd2,
                         S_WAIT = 3'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] dbg_state;
  int n_checks = 0;
  int n_errors = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];

  ah_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  ah_write_top #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Monitor on the falling edge, away from input changes and the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.user_write_buffer) got_q.push_back(bus.user_buffer_data);
      if (bus.control_go) go_cnt++;
      if (bus.write_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pushes(input string tag);
    chk({tag, "_push_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() != 0 && got_q.size() != 0)
      chk({tag, "_push_data"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // Issues an accepted start; returns in the first STREAM cycle.
  task automatic start_xfer(input logic [31:0] addr, input logic [31:0] sz);
    bus.write_addr = addr;
    bus.size = sz;
    bus.write_en = 1'b1;
    step();
    bus.write_en = 1'b0;
    #1;
    chk("start_state", dbg_state, S_START);
    chk("start_go", bus.control_go, 1'b1);
    chk("start_busy", bus.busy, 1'b1);
    chk("start_words_left", bus.words_left, sz >> 2);
    chk("start_base", bus.control_write_base, addr[ADDR_W-1:0]);
    chk("start_length", bus.control_write_length, sz[ADDR_W-1:0]);
    chk("start_ready", bus.data_ready, 1'b0);
    step();
    chk("stream_go_low", bus.control_go, 1'b0);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] val);
    int t = 0;
    bus.data_valid = 1'b1;
    bus.data_in = val;
    #1;
    while (!bus.data_ready && t < 20) begin
      step();
      t++;
    end
    chk("send_ready", bus.data_ready, 1'b1);
    exp_q.push_back(val);
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    int t = 0;
    while (dbg_state != S_WAIT && t < 30) begin
      step();
      t++;
    end
    chk({tag, "_wait_state"}, dbg_state, S_WAIT);
    chk({tag, "_wait_ready"}, bus.data_ready, 1'b0);
    check_pushes(tag);
    bus.control_done = 1'b1;
    step();
    bus.control_done = 1'b0;
    #1;
    chk({tag, "_write_done"}, bus.write_done, 1'b1);
    chk({tag, "_busy_in_done"}, bus.busy, 1'b1);
    step();
    chk({tag, "_done_low"}, bus.write_done, 1'b0);
    chk({tag, "_busy_low"}, bus.busy, 1'b0);
    chk({tag, "_idle"}, dbg_state, S_IDLE);
  endtask

  initial begin
    int go_before;
    int done_before;
    logic [31:0] bad_addr [4];
    logic [31:0] bad_size [4];
    bus.write_addr = '0;
    bus.size = '0;
    bus.write_en = 1'b0;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.control_done = 1'b0;
    bus.user_buffer_full = 1'b0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.data_ready, 1'b0);
    chk("rst_go", bus.control_go, 1'b0);
    chk("rst_done", bus.write_done, 1'b0);
    chk("rst_err", bus.write_err, 1'b0);
    chk("rst_uwb", bus.user_write_buffer, 1'b0);
    chk("rst_words_left", bus.words_left, 0);
    chk("rst_base", bus.control_write_base, 0);
    chk("rst_fixed", bus.control_fixed_location, 1'b0);
    reset = 1'b0;
    step();
    chk("idle_state", dbg_state, S_IDLE);

    // T1: four words back to back, no backpressure
    go_before = go_cnt;
    start_xfer(32'h100, 32'd16);
    for (int i = 1; i <= 4; i++) send_word(DATA_W'(i));
    finish_xfer("t1");
    chk("t1_go_once", go_cnt, go_before + 1);

    // T2: word held in the output register while the FIFO is full
    start_xfer(32'h800, 32'd8);
    bus.data_valid = 1'b1;
    bus.data_in = 32'hA5A5_0001;
    #1;
    chk("t2_ready_a", bus.data_ready, 1'b1);
    exp_q.push_back(32'hA5A5_0001);
    step();
    bus.user_buffer_full = 1'b1;
    bus.data_in = 32'hA5A5_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_full_ready", bus.data_ready, 1'b0);
      chk("t2_full_uwb", bus.user_write_buffer, 1'b0);
      chk("t2_full_hold", bus.user_buffer_data, 32'hA5A5_0001);
      chk("t2_full_words", bus.words_left, 1);
      step();
    end
    bus.user_buffer_full = 1'b0;
    #1;
    chk("t2_push_a", bus.user_write_buffer, 1'b1);
    chk("t2_ready_b", bus.data_ready, 1'b1);
    exp_q.push_back(32'hA5A5_0002);
    step();
    bus.data_valid = 1'b0;
    #1;
    chk("t2_push_b", bus.user_write_buffer, 1'b1);
    chk("t2_data_b", bus.user_buffer_data, 32'hA5A5_0002);
    finish_xfer("t2");

    // T3: rejected starts
    bad_addr = '{32'h100, 32'h100, 32'h102, 32'h100};
    bad_size = '{32'd0, 32'd6, 32'd16, 32'h0200_0000};
    go_before = go_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.write_addr = bad_addr[i];
      bus.size = bad_size[i];
      bus.write_en = 1'b1;
      step();
      bus.write_en = 1'b0;
      #1;
      chk("t3_err", bus.write_err, 1'b1);
      chk("t3_idle", dbg_state, S_IDLE);
      chk("t3_busy", bus.busy, 1'b0);
      step();
      chk("t3_err_pulse", bus.write_err, 1'b0);
    end
    chk("t3_no_go", go_cnt, go_before);

    // T4: restart and stray control_done during STREAM are ignored
    start_xfer(32'h200, 32'd16);
    bus.write_addr = 32'h300;
    bus.size = 32'd32;
    bus.write_en = 1'b1;
    bus.control_done = 1'b1;
    step();
    bus.write_en = 1'b0;
    bus.control_done = 1'b0;
    #1;
    chk("t4_state", dbg_state, S_STREAM);
    chk("t4_base", bus.control_write_base, 25'h200);
    chk("t4_length", bus.control_write_length, 25'd16);
    chk("t4_words", bus.words_left, 4);
    step();
    chk("t4_no_err", bus.write_err, 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h4000 + DATA_W'(i));
    finish_xfer("t4");

    // T5: reset mid-stream abandons the transfer
    done_before = done_cnt;
    start_xfer(32'h400, 32'd16);
    send_word(32'h5000);
    send_word(32'h5001);
    step();
    check_pushes("t5_partial");
    reset = 1'b1;
    step();
    chk("t5_rst_state", dbg_state, S_IDLE);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_uwb", bus.user_write_buffer, 1'b0);
    chk("t5_rst_ready", bus.data_ready, 1'b0);
    chk("t5_rst_words", bus.words_left, 0);
    chk("t5_rst_base", bus.control_write_base, 0);
    chk("t5_rst_length", bus.control_write_length, 0);
    reset = 1'b0;
    step();
    chk("t5_no_done", done_cnt, done_before);
    start_xfer(32'h40, 32'd4);
    send_word(32'h5555_AAAA);
    finish_xfer("t5");

    // T6: data_valid every other cycle, countdown in step
    start_xfer(32'h600, 32'd12);
    for (int k = 0; k < 3; k++) begin
      bus.data_valid = 1'b1;
      bus.data_in = 32'h60 + DATA_W'(k);
      #1;
      chk("t6_words_before", bus.words_left, 3 - k);
      chk("t6_ready", bus.data_ready, 1'b1);
      exp_q.push_back(32'h60 + DATA_W'(k));
      step();
      bus.data_valid = 1'b0;
      #1;
      chk("t6_words_after", bus.words_left, 2 - k);
      step();
    end
    finish_xfer("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
